// File: rtl/multiplexer_4x32.sv
// Registered 4:1 word multiplexer.
// One of four DATA_W-bit sources is chosen by a 2-bit selector and captured
// into an output register whenever in_valid is high. out_valid pulses for
// one cycle per capture. sel_q records which source produced the current word.
// Every output comes straight from a flop, so there is no combinational path
// from any input to any output.
module multiplexer_4x32 #(
    parameter int unsigned          DATA_W    = 32,
    parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   data0,
    input  logic [DATA_W-1:0]   data1,
    input  logic [DATA_W-1:0]   data2,
    input  logic [DATA_W-1:0]   data3,
    input  logic [1:0]          selector,
    input  logic                in_valid,
    output logic [DATA_W-1:0]   output_data,
    output logic                out_valid,
    output logic [1:0]          sel_q
);

    // The four sources, gathered so that the selector can index them.
    logic [DATA_W-1:0] sources [4];
    logic [DATA_W-1:0] selected_word;

    assign sources[0] = data0;
    assign sources[1] = data1;
    assign sources[2] = data2;
    assign sources[3] = data3;

    // Pure pass-through selection. Only the addressed source reaches
    // selected_word, so an unknown value on any other input cannot leak
    // through to the output.
    always_comb begin
        selected_word = sources[0];
        case (selector)
            2'b00:   selected_word = sources[0];
            2'b01:   selected_word = sources[1];
            2'b10:   selected_word = sources[2];
            2'b11:   selected_word = sources[3];
            default: selected_word = sources[0];
        endcase
    end

    // Capture register. Reset is asserted asynchronously and released on
    // the clock. A capture arriving while reset is low is discarded.
    // When in_valid is low, the data and selector registers keep their
    // contents and out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_data <= RESET_VAL;
            out_valid   <= 1'b0;
            sel_q       <= 2'b00;
        end else if (in_valid) begin
            output_data <= selected_word;
            out_valid   <= 1'b1;
            sel_q       <= selector;
        end else begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multiplexer_4x32.sv
// Directed self-checking bench for multiplexer_4x32.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit
// after the rising edge, except in the asynchronous reset checks.
module tb_multiplexer_4x32;

    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] data0, data1, data2, data3;
    logic [1:0]        selector;
    logic              in_valid;
    logic [DATA_W-1:0] output_data;
    logic              out_valid;
    logic [1:0]        sel_q;

    int compared   = 0;
    int mismatched = 0;

    multiplexer_4x32 #(
        .DATA_W    (DATA_W),
        .RESET_VAL ('0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data0       (data0),
        .data1       (data1),
        .data2       (data2),
        .data3       (data3),
        .selector    (selector),
        .in_valid    (in_valid),
        .output_data (output_data),
        .out_valid   (out_valid),
        .sel_q       (sel_q)
    );

    // 10-unit clock, first rising edge at t=5
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: report tag, observed and expected on mismatch
    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check all three outputs against expected values
    task automatic check_all(input string tag, input logic [DATA_W-1:0] exp_data,
                             input logic exp_valid, input logic [1:0] exp_sel);
        check({tag, ".data"},  output_data, exp_data);
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
        check({tag, ".sel"},   {30'd0, sel_q},     {30'd0, exp_sel});
        $display("step %-12s data=%h valid=%0b sel=%0d", tag, output_data, out_valid, sel_q);
    endtask

    // Drive one cycle of stimulus at the falling edge, then sample after the rising edge
    task automatic cycle(input logic [1:0] sel, input logic vld);
        @(negedge clk);
        selector = sel;
        in_valid = vld;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b1;
        selector = 2'b01;
        data0    = 32'h1234_5678;
        data1    = 32'h8765_4321;
        data2    = 32'h1111_2222;
        data3    = 32'h3333_4444;

        // 1: asynchronous reset, asserted before any clock edge, with in_valid high
        #1 rst_n = 1'b0;
        #1 check_all("rst_async", 32'h0, 1'b0, 2'b00);
        cycle(2'b11, 1'b1);
        check_all("rst_held1", 32'h0, 1'b0, 2'b00);
        cycle(2'b10, 1'b1);
        check_all("rst_held2", 32'h0, 1'b0, 2'b00);
        @(negedge clk) rst_n = 1'b1;

        // 2: first capture after release
        cycle(2'b00, 1'b1);
        check_all("sel00", 32'h1234_5678, 1'b1, 2'b00);

        // 3: remaining selector codes, back to back
        cycle(2'b10, 1'b1);
        check_all("sel10", 32'h1111_2222, 1'b1, 2'b10);
        cycle(2'b01, 1'b1);
        check_all("sel01", 32'h8765_4321, 1'b1, 2'b01);
        cycle(2'b11, 1'b1);
        check_all("sel11", 32'h3333_4444, 1'b1, 2'b11);

        // 4: hold while in_valid is low, with selector and data wiggling
        cycle(2'b10, 1'b1);
        check_all("hold_cap", 32'h1111_2222, 1'b1, 2'b10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            selector = 2'(i);
            data0 = 32'hDEAD_0000 + 32'(i);
            data1 = 32'hBEEF_0000 + 32'(i);
            data2 = 32'hCAFE_0000 + 32'(i);
            data3 = 32'hF00D_0000 + 32'(i);
            @(posedge clk);
            #1;
            check_all($sformatf("hold%0d", i), 32'h1111_2222, 1'b0, 2'b10);
        end

        // 5: streaming. Data and selector change on the same cycle as in_valid;
        // the values present at each sampling edge must be used.
        @(negedge clk);
        data0 = 32'hA0A0_0001; data1 = 32'hB1B1_0002;
        data2 = 32'hC2C2_0003; data3 = 32'hD3D3_0004;
        selector = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        check_all("strm00", 32'hA0A0_0001, 1'b1, 2'b00);
        cycle(2'b01, 1'b1);
        check_all("strm01", 32'hB1B1_0002, 1'b1, 2'b01);
        cycle(2'b10, 1'b1);
        check_all("strm10", 32'hC2C2_0003, 1'b1, 2'b10);
        @(negedge clk);
        data3 = 32'h0BAD_CAFE; selector = 2'b11;
        @(posedge clk); #1;
        check_all("strm11", 32'h0BAD_CAFE, 1'b1, 2'b11);

        // X on a non-selected input must not reach the output
        @(negedge clk);
        data3 = 'x; data2 = 'x; selector = 2'b01;
        @(posedge clk); #1;
        check_all("x_unsel", 32'hB1B1_0002, 1'b1, 2'b01);
        @(negedge clk);
        data2 = 32'hC2C2_0003; data3 = 32'hD3D3_0004;

        // 6: reset mid-stream, asserted between clock edges
        cycle(2'b10, 1'b1);
        check_all("pre_rst", 32'hC2C2_0003, 1'b1, 2'b10);
        #1 rst_n = 1'b0;
        #1 check_all("rst_mid", 32'h0, 1'b0, 2'b00);
        cycle(2'b11, 1'b1);
        check_all("rst_drop", 32'h0, 1'b0, 2'b00);
        @(negedge clk) rst_n = 1'b1;
        cycle(2'b11, 1'b1);
        check_all("post_rst", 32'hD3D3_0004, 1'b1, 2'b11);
        cycle(2'b00, 1'b0);
        check_all("post_idle", 32'hD3D3_0004, 1'b0, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
